// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit:
// states, opcode/funct codes, ula32 ops and datapath selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_MEM = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_EXC    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [2:0] PCS_ALU    = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_EXC    = 3'd3;

  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;

  localparam logic [2:0] SRCB_B    = 3'd0;
  localparam logic [2:0] SRCB_4    = 3'd1;
  localparam logic [2:0] SRCB_IMM  = 3'd2;
  localparam logic [2:0] SRCB_IMM2 = 3'd3;

  localparam logic [3:0] M2R_ALUOUT = 4'd0;
  localparam logic [3:0] M2R_MDR    = 4'd1;

  typedef struct packed {
    logic       pcwrite;
    logic [2:0] pcsource;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [2:0] aluop;
    logic       iord;
    logic       memwr;
    logic       irwrite;
    logic       mdrwrite;
    logic       abwrite;
    logic       aluoutwrite;
    logic       epcwrite;
    logic       regwrite;
    logic       regdst;
    logic [3:0] memtoreg;
  } ctrl_t;

  function automatic logic is_arith(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

  function automatic logic is_rfunct(input logic [5:0] fn);
    return is_arith(fn) || (fn == FN_AND);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Memory wait-state counter; done marks the last cycle
// of a FETCH or MEM_RD access.
module wait_counter
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= 3'd0;
    else                cnt <= cnt + 3'd1;
  end

  assign done = (cnt == 3'(MEM_WAIT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM with memory wait states,
// overflow/invalid-opcode exceptions and beq/bne.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 1,
  parameter bit          OVF_EXC    = 1'b1,
  parameter logic [31:0] EXC_VECTOR = 32'd255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Overflow,
  input  logic       Igual,
  output logic       PCWrite,
  output logic [2:0] PCSource,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       Iord,
  output logic       MemWr,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] MemToReg,
  output logic [3:0] state_dbg
);

  // A zero vector would alias the reset entry point.
  if (MEM_WAIT > 7 || EXC_VECTOR == 32'd0) begin : g_bad_cfg
    $error("multicycle_ctrl: bad MEM_WAIT or EXC_VECTOR");
  end

  state_t state;
  logic   done;
  logic   clear;
  logic   ovf_trap;
  ctrl_t  c;
  ctrl_t  co;

  assign clear = ((state != S_FETCH) && (state != S_MEM_RD)) || done;
  assign ovf_trap = OVF_EXC && Overflow;

  wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .done (done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (done) state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            (opcode == OP_RTYPE) && is_rfunct(funct):
              state <= S_EXEC_R;
            opcode == OP_ADDI:
              state <= S_EXEC_I;
            (opcode == OP_LW) || (opcode == OP_SW):
              state <= S_ADDR;
            (opcode == OP_BEQ) || (opcode == OP_BNE):
              state <= S_BRANCH;
            opcode == OP_J:
              state <= S_JUMP;
            default:
              state <= S_EXC;
          endcase
        end
        S_EXEC_R:
          state <= (ovf_trap && is_arith(funct)) ? S_EXC : S_WB_R;
        S_EXEC_I:
          state <= ovf_trap ? S_EXC : S_WB_I;
        S_ADDR:
          state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (done) state <= S_WB_MEM;
        S_MEM_WR: state <= S_FETCH;
        S_WB_R:   state <= S_FETCH;
        S_WB_I:   state <= S_FETCH;
        S_WB_MEM: state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_EXC:    state <= S_FETCH;
        default:  state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        if (done) begin
          c.irwrite  = 1'b1;
          c.pcwrite  = 1'b1;
          c.alusrca  = SRCA_PC;
          c.alusrcb  = SRCB_4;
          c.aluop    = ALU_ADD;
          c.pcsource = PCS_ALU;
        end
      end
      S_DECODE: begin
        c.abwrite     = 1'b1;
        c.alusrca     = SRCA_PC;
        c.alusrcb     = SRCB_IMM2;
        c.aluop       = ALU_ADD;
        c.aluoutwrite = 1'b1;
      end
      S_EXEC_R: begin
        c.alusrca     = SRCA_A;
        c.alusrcb     = SRCB_B;
        c.aluoutwrite = 1'b1;
        unique case (1'b1)
          funct == FN_SUB: c.aluop = ALU_SUB;
          funct == FN_AND: c.aluop = ALU_AND;
          default:         c.aluop = ALU_ADD;
        endcase
      end
      S_EXEC_I, S_ADDR: begin
        c.alusrca     = SRCA_A;
        c.alusrcb     = SRCB_IMM;
        c.aluop       = ALU_ADD;
        c.aluoutwrite = 1'b1;
      end
      S_MEM_RD: begin
        c.iord     = 1'b1;
        c.mdrwrite = done;
      end
      S_MEM_WR: begin
        c.iord  = 1'b1;
        c.memwr = 1'b1;
      end
      S_WB_R: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.memtoreg = M2R_ALUOUT;
      end
      S_WB_I: begin
        c.regwrite = 1'b1;
        c.memtoreg = M2R_ALUOUT;
      end
      S_WB_MEM: begin
        c.regwrite = 1'b1;
        c.memtoreg = M2R_MDR;
      end
      S_BRANCH: begin
        c.alusrca  = SRCA_A;
        c.alusrcb  = SRCB_B;
        c.aluop    = ALU_CMP;
        c.pcsource = PCS_ALUOUT;
        c.pcwrite  = (opcode == OP_BEQ) ? Igual : !Igual;
      end
      S_JUMP: begin
        c.pcsource = PCS_JUMP;
        c.pcwrite  = 1'b1;
      end
      S_EXC: begin
        c.alusrca  = SRCA_PC;
        c.alusrcb  = SRCB_4;
        c.aluop    = ALU_SUB;
        c.epcwrite = 1'b1;
        c.pcsource = PCS_EXC;
        c.pcwrite  = 1'b1;
      end
      default: c = '0;
    endcase
  end

  // Reset masks every strobe at once, even mid-access.
  assign co = reset ? '0 : c;

  assign PCWrite     = co.pcwrite;
  assign PCSource    = co.pcsource;
  assign ALUSrcA     = co.alusrca;
  assign ALUSrcB     = co.alusrcb;
  assign ALUOp       = co.aluop;
  assign Iord        = co.iord;
  assign MemWr       = co.memwr;
  assign IRWrite     = co.irwrite;
  assign MDRWrite    = co.mdrwrite;
  assign ABWrite     = co.abwrite;
  assign ALUOutWrite = co.aluoutwrite;
  assign EPCWrite    = co.epcwrite;
  assign RegWrite    = co.regwrite;
  assign RegDst      = co.regdst;
  assign MemToReg    = co.memtoreg;
  assign state_dbg   = reset ? 4'd0 : state;

endmodule
